sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//  Command arbiter directly downstream of the auto-refresh, write and read engines. Grants the SDRAM bus to one requester at a time.
//  Returns grants on the *_access pulses and multiplexes the winner's command/address onto the SDRAM pins.
//  Auto-refresh has absolute priority. During initialisation the init sequencer owns the bus.
// PARAMETERS
//  CMD_NOP       4'b0111  NOP encoding {CS_n,RAS_n,CAS_n,WE_n}, driven whenever no owner
//  WDOG_CYCLES   1023     max cycles in AREF/WRITE/READ before forced release (10-bit counter)
// PORTS
//  Sys_clk         in   1   system clock; all logic on rising edge
//  Rst             in   1   synchronous, active-high reset
//  INIT_DONE       in   1   init sequencer finished (level)
//  COMMAND_INIT    in   4   init command;  INIT_A_ADDR in 12, INIT_BANK_ADDR in 2
//  ARF_req         in   1   refresh request (level, held until ARF_access)
//  REF_DONE        in   1   refresh sequence complete (1-cycle pulse)
//  COMMAND_REF     in   4   refresh command;  ARF_A_ADDR in 12, ARF_BANK_ADDR in 2
//  WR_req / RD_req in   1   write / read request (level, held until access)
//  WR_DONE/RD_DONE in   1   burst complete (1-cycle pulse)
//  COMMAND_WR/_RD  in   4   write/read command; WR_A_ADDR/RD_A_ADDR in 12, WR_/RD_BANK_ADDR in 2
//  ARF_access      out  1   refresh grant, 1-cycle pulse
//  WR_access       out  1   write grant, 1-cycle pulse
//  RD_access       out  1   read grant, 1-cycle pulse
//  ARF_PENDING     out  1   ARF_req seen while WRITE/READ owns bus; engines end burst early
//  SDRAM_CMD       out  4   muxed command
//  SDRAM_A_ADDR    out  12  muxed address
//  SDRAM_BA        out  2   muxed bank
//  WDOG_ERR        out  1   1-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset: state=INIT.
//   - SDRAM_CMD=CMD_NOP; SDRAM_A_ADDR=0; SDRAM_BA=0.
//   - All *_access=0; ARF_PENDING=0; WDOG_ERR=0; watchdog=0.
//   - Reset mid-burst aborts immediately with no pending grant retained.
//  States and transitions:
//   - INIT: INIT_DONE=1 -> ARB.
//   - ARB: ARF_req -> AREF, else WR_req -> WRITE, else RD_req -> READ.
//   - AREF: REF_DONE -> ARB.
//   - WRITE: WR_DONE -> ARB.
//   - READ: RD_DONE -> ARB.
//  Grants:
//   - Each *_access is registered and pulses exactly on the cycle the FSM enters the matching state.
//   - ARB is always occupied for >=1 cycle between owners.
//   - A request and a DONE in the same cycle: DONE is honoured first; the grant is issued one cycle later from ARB.
//  Mux:
//   - Outputs are registered, one-cycle latency from the owning source.
//   - INIT passes the init bus; AREF/WRITE/READ pass their source's bus.
//   - ARB drives CMD_NOP with address and bank 0.
//  ARF_PENDING:
//   - Set when ARF_req=1 in WRITE or READ.
//   - Cleared on entry to ARB or on reset.
//  Watchdog:
//   - 10-bit counter, zeroed on entering AREF/WRITE/READ, increments each cycle while there.
//   - At WDOG_CYCLES: force ARB, pulse WDOG_ERR, drive CMD_NOP.
//   - A DONE arriving in that same cycle suppresses WDOG_ERR.
//  DONE pulses from a non-owner are ignored. INIT_DONE dropping outside INIT is ignored.
// CONFIGURATION
//  SDRAM_ARB_RR_EN defined:
//   - WR/RD priority alternates. After a WRITE grant, RD wins the next WR/RD tie; after a READ grant, WR wins.
//   - Refresh stays absolute priority; the RR pointer resets to WR-first.
//  SDRAM_ARB_RR_EN undefined: fixed priority ARF > WR > RD.
// TESTING
//  1. Rst=1 3 cycles, INIT_DONE=0 -> SDRAM_CMD=4'b0111, all access=0, COMMAND_INIT passed after one cycle.
//  2. INIT_DONE=1, then ARF_req=1 and WR_req=1 same cycle -> ARF_access single pulse, WR_access=0.
//     - Then REF_DONE at cycle 9 -> ARB 1 cycle -> WR_access pulse.
//  3. In WRITE, assert ARF_req -> ARF_PENDING=1 next cycle.
//     - Then WR_DONE -> ARF_PENDING=0 -> ARF_access follows 1 cycle after ARB entry.
//  4. WR_req=RD_req=1 continuously, DONE after 4 cycles each.
//     - Without RR: grants WR,WR,WR.
//     - With SDRAM_ARB_RR_EN: grants WR,RD,WR,RD.
//  5. Grant READ, never pulse RD_DONE -> after 1023 cycles WDOG_ERR pulses once, SDRAM_CMD=4'b0111, state ARB.
//  6. Rst=1 for one cycle mid-WRITE -> next cycle state INIT, SDRAM_CMD=4'b0111, no access pulse after release.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - request/grant and SDRAM pin bundle between the engines and the arbiter
//
// Purpose: groups the init, refresh, write and read engine buses with the
// arbiter grants and the multiplexed SDRAM command/address pins.
// Modports:
//   master - engines side: drives requests, DONE pulses, commands and addresses;
//            observes grants, ARF_PENDING, the SDRAM pins and WDOG_ERR.
//   slave  - arbiter side: the mirror image of master.
interface sdram_arbiter_if;
   logic        INIT_DONE;
   logic [3:0]  COMMAND_INIT;
   logic [11:0] INIT_A_ADDR;
   logic [1:0]  INIT_BANK_ADDR;

   logic        ARF_req;
   logic        REF_DONE;
   logic [3:0]  COMMAND_REF;
   logic [11:0] ARF_A_ADDR;
   logic [1:0]  ARF_BANK_ADDR;

   logic        WR_req;
   logic        WR_DONE;
   logic [3:0]  COMMAND_WR;
   logic [11:0] WR_A_ADDR;
   logic [1:0]  WR_BANK_ADDR;

   logic        RD_req;
   logic        RD_DONE;
   logic [3:0]  COMMAND_RD;
   logic [11:0] RD_A_ADDR;
   logic [1:0]  RD_BANK_ADDR;

   logic        ARF_access;
   logic        WR_access;
   logic        RD_access;
   logic        ARF_PENDING;
   logic [3:0]  SDRAM_CMD;
   logic [11:0] SDRAM_A_ADDR;
   logic [1:0]  SDRAM_BA;
   logic        WDOG_ERR;

   modport master (
      output INIT_DONE, COMMAND_INIT, INIT_A_ADDR, INIT_BANK_ADDR,
      output ARF_req, REF_DONE, COMMAND_REF, ARF_A_ADDR, ARF_BANK_ADDR,
      output WR_req, WR_DONE, COMMAND_WR, WR_A_ADDR, WR_BANK_ADDR,
      output RD_req, RD_DONE, COMMAND_RD, RD_A_ADDR, RD_BANK_ADDR,
      input  ARF_access, WR_access, RD_access, ARF_PENDING,
      input  SDRAM_CMD, SDRAM_A_ADDR, SDRAM_BA, WDOG_ERR
   );

   modport slave (
      input  INIT_DONE, COMMAND_INIT, INIT_A_ADDR, INIT_BANK_ADDR,
      input  ARF_req, REF_DONE, COMMAND_REF, ARF_A_ADDR, ARF_BANK_ADDR,
      input  WR_req, WR_DONE, COMMAND_WR, WR_A_ADDR, WR_BANK_ADDR,
      input  RD_req, RD_DONE, COMMAND_RD, RD_A_ADDR, RD_BANK_ADDR,
      output ARF_access, WR_access, RD_access, ARF_PENDING,
      output SDRAM_CMD, SDRAM_A_ADDR, SDRAM_BA, WDOG_ERR
   );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM command arbiter for init, refresh, write and read engines
//
// Purpose: grants the SDRAM bus to one engine at a time and muxes the owner's
// command/address onto the SDRAM pins (registered, one cycle of latency).
// Auto-refresh has absolute priority; the init sequencer owns the bus until
// INIT_DONE. Optional macro SDRAM_ARB_RR_EN makes WR/RD ties alternate
// (default build: fixed priority ARF > WR > RD).
// Ports:
//   Sys_clk  - system clock, rising edge
//   Rst      - synchronous active-high reset
//   bus      - sdram_arbiter_if.slave: engine requests/DONE/commands in;
//              *_access grant pulses, ARF_PENDING, SDRAM_CMD/A_ADDR/BA, WDOG_ERR out
module sdram_arbiter #(
   parameter logic [3:0]  CMD_NOP     = 4'b0111,
   parameter int unsigned WDOG_CYCLES = 1023
) (
   input  logic           Sys_clk,
   input  logic           Rst,
   sdram_arbiter_if.slave bus
);
   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_ARB   = 3'd1,
      S_AREF  = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4
   } state_t;

   localparam logic [9:0] WDOG_LIMIT = 10'(WDOG_CYCLES);

   state_t      r_state;
   state_t      w_next_state;
   logic [9:0]  r_wdog;
   logic        w_owner;
   logic        w_done;
   logic        w_wdog_fire;
   logic        w_wr_first;

   logic        r_arf_access;
   logic        r_wr_access;
   logic        r_rd_access;
   logic        r_arf_pending;
   logic        r_wdog_err;
   logic [3:0]  r_cmd;
   logic [11:0] r_addr;
   logic [1:0]  r_ba;

`ifdef SDRAM_ARB_RR_EN
   // Set after a WRITE grant so READ wins the next WR/RD tie; cleared after a READ grant.
   logic        r_rd_first;
   assign w_wr_first = ~r_rd_first;
`else
   assign w_wr_first = 1'b1;
`endif

   always_comb begin
      w_next_state = r_state;
      w_owner      = 1'b0;
      w_done       = 1'b0;
      w_wdog_fire  = 1'b0;
      case (r_state)
         S_INIT: begin
            if (bus.INIT_DONE) w_next_state = S_ARB;
         end
         S_ARB: begin
            if (bus.ARF_req)
               w_next_state = S_AREF;
            else if (bus.WR_req && (!bus.RD_req || w_wr_first))
               w_next_state = S_WRITE;
            else if (bus.RD_req)
               w_next_state = S_READ;
         end
         S_AREF: begin
            w_owner = 1'b1;
            w_done  = bus.REF_DONE;
         end
         S_WRITE: begin
            w_owner = 1'b1;
            w_done  = bus.WR_DONE;
         end
         S_READ: begin
            w_owner = 1'b1;
            w_done  = bus.RD_DONE;
         end
         default: w_next_state = S_INIT;
      endcase
      // Only the owner's DONE is looked at, so stray DONEs from other engines fall out here.
      if (w_owner) begin
         w_wdog_fire = (r_wdog == WDOG_LIMIT);
         if (w_done || w_wdog_fire) w_next_state = S_ARB;
      end
   end

   always_ff @(posedge Sys_clk) begin
      if (Rst) begin
         r_state       <= S_INIT;
         r_wdog        <= '0;
         r_arf_access  <= 1'b0;
         r_wr_access   <= 1'b0;
         r_rd_access   <= 1'b0;
         r_arf_pending <= 1'b0;
         r_wdog_err    <= 1'b0;
         r_cmd         <= CMD_NOP;
         r_addr        <= '0;
         r_ba          <= '0;
`ifdef SDRAM_ARB_RR_EN
         r_rd_first    <= 1'b0;
`endif
      end else begin
         r_state <= w_next_state;

         // Grants only ever leave ARB, so each pulse lines up with the first cycle in the owner state.
         r_arf_access <= (r_state == S_ARB) && (w_next_state == S_AREF);
         r_wr_access  <= (r_state == S_ARB) && (w_next_state == S_WRITE);
         r_rd_access  <= (r_state == S_ARB) && (w_next_state == S_READ);

`ifdef SDRAM_ARB_RR_EN
         if (r_state == S_ARB && w_next_state == S_WRITE)
            r_rd_first <= 1'b1;
         else if (r_state == S_ARB && w_next_state == S_READ)
            r_rd_first <= 1'b0;
`endif

         if (w_next_state != r_state)
            r_wdog <= '0;
         else if (w_owner)
            r_wdog <= r_wdog + 10'd1;

         // A DONE landing on the expiry cycle is a legitimate finish, not a hang.
         r_wdog_err <= w_wdog_fire && !w_done;

         if (w_next_state == S_ARB)
            r_arf_pending <= 1'b0;
         else if ((r_state == S_WRITE || r_state == S_READ) && bus.ARF_req)
            r_arf_pending <= 1'b1;

         case (r_state)
            S_INIT: begin
               r_cmd  <= bus.COMMAND_INIT;
               r_addr <= bus.INIT_A_ADDR;
               r_ba   <= bus.INIT_BANK_ADDR;
            end
            S_AREF: begin
               r_cmd  <= bus.COMMAND_REF;
               r_addr <= bus.ARF_A_ADDR;
               r_ba   <= bus.ARF_BANK_ADDR;
            end
            S_WRITE: begin
               r_cmd  <= bus.COMMAND_WR;
               r_addr <= bus.WR_A_ADDR;
               r_ba   <= bus.WR_BANK_ADDR;
            end
            S_READ: begin
               r_cmd  <= bus.COMMAND_RD;
               r_addr <= bus.RD_A_ADDR;
               r_ba   <= bus.RD_BANK_ADDR;
            end
            default: begin
               r_cmd  <= CMD_NOP;
               r_addr <= '0;
               r_ba   <= '0;
            end
         endcase
         // A forced release must not leave the hung engine's command on the pins.
         if (w_wdog_fire) begin
            r_cmd  <= CMD_NOP;
            r_addr <= '0;
            r_ba   <= '0;
         end
      end
   end

   assign bus.ARF_access   = r_arf_access;
   assign bus.WR_access    = r_wr_access;
   assign bus.RD_access    = r_rd_access;
   assign bus.ARF_PENDING  = r_arf_pending;
   assign bus.WDOG_ERR     = r_wdog_err;
   assign bus.SDRAM_CMD    = r_cmd;
   assign bus.SDRAM_A_ADDR = r_addr;
   assign bus.SDRAM_BA     = r_ba;
endmodule
